// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file operand path: widths, the opcode
// that marks a register write, and the write-back queue entry layout.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int OP_W       = 4;

    // Only Type A results update the register file; all others just retire.
    localparam logic [OP_W-1:0] OP_TYPE_A = 4'hF;

    // One queued write-back: payload, destination index and write qualifier.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dest;
        logic                  is_write;
    } wb_entry_t;

    // Decide at enqueue time whether a result will touch the register file.
    function automatic logic is_type_a(input logic [OP_W-1:0] opcode);
        return opcode == OP_TYPE_A;
    endfunction

    // One-hot register mask for a destination index.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] dest);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[dest] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order DEPTH-entry queue of write-back entries. Besides the usual head and
// status flags it exposes the raw storage and a per-slot occupancy vector so
// the parent can scan every live entry (for hazard tracking) in one cycle.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wb_entry_t                entry_i,
    output wb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output wb_entry_t [DEPTH-1:0]    entries_o,
    output logic [DEPTH-1:0]         occupied_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fill_q,   fill_d;
    wb_entry_t [DEPTH-1:0] mem_q,    mem_d;

    logic do_push;
    logic do_pop;
    logic [PTR_W-1:0] slot_off;

    // Status flags; fill alone distinguishes full from empty since the
    // pointers coincide in both cases.
    assign full_o  = (fill_q == CNT_W'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;

    // Next-state computation for pointers, occupancy count and storage.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = entry_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Slot i is live when its distance from the read pointer is below fill.
    always_comb begin
        occupied_o = '0;
        slot_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off      = PTR_W'(i) - rd_ptr_q;
            occupied_o[i] = ({1'b0, slot_off} < fill_q);
        end
    end

    // State register for pointers, count and storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            // NOTE: storage is cleared too because the raw entry array is exported and must not show stale data after reset.
            mem_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            mem_q    <= mem_d;
        end
    end

    // Occupancy never exceeds capacity.
    a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fill_q <= CNT_W'(DEPTH));

    // Pointer distance agrees with fill (modulo DEPTH).
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        PTR_W'(wr_ptr_q - rd_ptr_q) == fill_q[PTR_W-1:0]);

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: queues ALU results behind a valid/ready handshake, drains
// them in order through the register file's single write port, and publishes
// a mask of registers that still have a write in flight.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    result_valid,
    output logic                    result_ready,
    input  logic [DATA_W-1:0]       result_data,
    input  logic [REG_ADDR_W-1:0]   result_dest,
    input  logic [OP_W-1:0]         result_opcode,
    input  logic                    wr_stall,
    output logic                    wr_en,
    output logic [REG_ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [NUM_REGS-1:0]     pending,
    output logic [$clog2(DEPTH):0]  fill
);

    wb_entry_t             new_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      occupied;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_push;
    logic                  q_pop;

    // The write qualifier is decoded once, on entry, so the head drive and
    // the pending scan never need the opcode again.
    assign new_entry = '{data:     result_data,
                         dest:     result_dest,
                         is_write: is_type_a(result_opcode)};

    // Ready depends on occupancy only, which keeps valid->ready loop-free.
    assign result_ready = !q_full;
    assign q_push       = result_valid && result_ready;

    // The head retires whenever the write port is free, write or not.
    assign q_pop = !q_empty && !wr_stall;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (q_push),
        .pop_i      (q_pop),
        .entry_i    (new_entry),
        .head_o     (head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .fill_o     (fill),
        .entries_o  (entries),
        .occupied_o (occupied)
    );

    // Register file write port, driven straight from the queue head.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!q_empty) begin
            wr_addr = head.dest;
            wr_data = head.data;
            wr_en   = head.is_write && !wr_stall;
        end
    end

    // Hazard mask: every live write contributes its destination bit.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && entries[i].is_write) begin
                pending = pending | reg_onehot(entries[i].dest);
            end
        end
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage for the 16 x 16-bit register file: the writer side of the operand path. It accepts ALU results with their destination register and opcode over a valid/ready handshake and buffers them in a small in-order queue. It drives the register file's single write port, one result per cycle. It also exports a pending-destination mask so the decode/operand-read stage can stall on read-after-write hazards.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- result_valid  input  1  result_data/dest/opcode valid this cycle
- result_ready  output  1  queue can accept; high iff fill < DEPTH
- result_data  input  16  ALU result
- result_dest  input  4  destination register index 0..15
- result_opcode  input  4  opcode travelling with the result
- wr_stall  input  1  register file write port unavailable this cycle
- wr_en  output  1  register file write strobe
- wr_addr  output  4  register file write index
- wr_data  output  16  register file write data
- pending  output  16  bit i set iff a queued entry will write register i
- fill  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Accept when result_valid && result_ready at a rising edge; push {data, dest, is_write} at the tail.
- is_write = (result_opcode == 4'hF), Type A. Other opcodes are queued and popped in order but never assert wr_en.
- Head drive is combinational from queue state:
  - wr_addr = head dest, wr_data = head data (both 0 when empty)
  - wr_en = !empty && head.is_write && !wr_stall
- Pop when !empty && !wr_stall, regardless of is_write.
- Push and pop in the same cycle: fill is unchanged and both pointers advance.
- pending = OR of onehot(dest) over occupied entries with is_write. It is combinational from queue state, and a register stays pending until its last queued write pops.
- Pointers wrap modulo DEPTH. fill is the only full/empty discriminator.
- All 16 register indices are writable. Index 0 gets no special treatment.

## Timing
- Reset values: fill=0, result_ready=1, wr_en=0, wr_addr=0, wr_data=0, pending=0. Both pointers are 0.
- Latency: an entry accepted at edge k into an empty queue drives wr_en in the cycle after edge k. The register file captures it at edge k+1.
- Throughput: one push and one pop per cycle. With no stall, a continuous stream never deasserts result_ready.
- Full (fill == DEPTH): result_ready=0 and nothing is accepted, even if a pop occurs that cycle. result_ready rises the cycle after the pop.
- Empty: wr_en=0 and a stall has no effect. A push into the empty queue is visible at the head the next cycle; there is no same-cycle bypass.
- wr_stall high: the head holds, wr_en=0, and pushes continue until full.
- Reset mid-operation: the queue contents are discarded and no further writes occur. Outputs take their reset values asynchronously.
- result_ready depends only on fill, not on result_valid, so there is no combinational loop.

## Structure
- Shared package (`cpu_pkg`):
  - DATA_W=16, REG_ADDR_W=4, NUM_REGS=16
  - OP_TYPE_A=4'hF
  - a wb_entry_t struct {data, dest, is_write}
- Sub-module `wb_fifo`: synchronous DEPTH-entry FIFO of wb_entry_t.
  - Inputs: push, pop.
  - Outputs: head, full, empty, fill, and the raw entry array plus occupancy vector.
  - reg_writeback adds the is_write decode, the wr_* drive, and the pending-mask reduction.

## Test plan
- Reset then a single push of {0x1234, dest 3, op F}:
  - wr_en=1, wr_addr=3, wr_data=0x1234 for exactly one cycle
  - pending[3] high for that cycle only, fill returns to 0
- Push op 4'h2, dest 5 -> entry pops after one cycle, wr_en stays 0, pending stays 0.
- wr_stall held high while pushing 5 Type A entries, DEPTH=4:
  - first 4 accepted, result_ready drops after the 4th, fill=4
  - releasing the stall drains them in order, one per cycle
- Two queued writes to dest 7, then a stall release -> pending[7] stays high until the second write pops, then clears.
- Continuous push of 8 results with no stall -> result_ready stays 1, fill never exceeds 1, and wr_data follows the input sequence one cycle late.
- Assert reset low mid-drain with fill=3 -> outputs at reset values immediately; after release, no stale wr_en pulses.
